// File: rtl/stack_judge.sv
// Gameplay judge: slides the current row block across the playfield, catches the drop,
// trims the block to its overlap with the row below and reports success or failure.
module stack_judge #(
   parameter int          NUM_COLS     = 16,
   parameter int          BLOCK_INIT_W = 4,
   parameter logic [23:0] TICK_BASE    = 24'd5_000_000,
   parameter logic [23:0] TICK_STEP    = 24'd300_000,
   parameter logic [23:0] TICK_MIN     = 24'd1_000_000,
   localparam int         COL_W        = $clog2(NUM_COLS)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [3:0]       level,
   input  logic             drop,
   input  logic             done_plot,
   output logic [COL_W-1:0] block_x,
   output logic [COL_W:0]   block_w,
   output logic [COL_W-1:0] base_x,
   output logic [COL_W:0]   base_w,
   output logic             next_signal,
   output logic             fail,
   output logic             plot_req
);

   localparam int CW1 = COL_W + 1;
   localparam logic [COL_W:0]   COLS_N  = CW1'(NUM_COLS);
   localparam logic [COL_W:0]   INIT_W  = CW1'(BLOCK_INIT_W);
   localparam logic [COL_W-1:0] BASE_X0 = COL_W'((NUM_COLS - BLOCK_INIT_W) / 2);
   localparam logic [3:0]       LAST_LEVEL = 4'd14;

   typedef enum logic [1:0] {
      S_MOVE  = 2'd0,
      S_JUDGE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   // Reload value for the move countdown: max(BASE - L*STEP, MIN) - 1, kept wide to avoid wrap.
   function automatic logic [23:0] period_m1(input logic [3:0] lvl);
      logic [27:0] dec;
      logic [27:0] per;
      dec = 28'(lvl) * 28'(TICK_STEP);
      if (dec + 28'(TICK_MIN) >= 28'(TICK_BASE)) begin
         per = 28'(TICK_MIN);
      end else begin
         per = 28'(TICK_BASE) - dec;
      end
      return 24'(per - 28'd1);
   endfunction

   state_e           state_q, state_d;
   logic [COL_W-1:0] block_x_q, block_x_d;
   logic [COL_W:0]   block_w_q, block_w_d;
   logic [COL_W-1:0] base_x_q, base_x_d;
   logic [COL_W:0]   base_w_q, base_w_d;
   logic             dir_left_q, dir_left_d;
   logic [23:0]      tick_q, tick_d;
   logic             wait_first_q, wait_first_d;
   logic             next_q, next_d;
   logic             fail_q, fail_d;
   logic             plot_q, plot_d;

   logic [COL_W:0]   block_end;
   logic [COL_W:0]   base_end;
   logic [COL_W:0]   ov_lo;
   logic [COL_W:0]   ov_hi;

   always_comb begin
      block_end = {1'b0, block_x_q} + block_w_q;
      base_end  = {1'b0, base_x_q} + base_w_q;
      ov_lo     = (block_x_q > base_x_q) ? {1'b0, block_x_q} : {1'b0, base_x_q};
      ov_hi     = (block_end < base_end) ? block_end : base_end;
   end

   always_comb begin
      state_d      = state_q;
      block_x_d    = block_x_q;
      block_w_d    = block_w_q;
      base_x_d     = base_x_q;
      base_w_d     = base_w_q;
      dir_left_d   = dir_left_q;
      tick_d       = tick_q;
      wait_first_d = wait_first_q;
      next_d       = 1'b0;
      fail_d       = 1'b0;
      plot_d       = 1'b0;

      case (state_q)
         S_MOVE: begin
            if (drop) begin
               state_d = S_JUDGE;
            end else if (tick_q == 24'd0) begin
               tick_d = period_m1(level);
               plot_d = 1'b1;
               // A full-width block has nowhere to go and simply stays put at the wall.
               if (!dir_left_q) begin
                  if (block_end == COLS_N) begin
                     dir_left_d = 1'b1;
                     if (block_x_q != '0) block_x_d = block_x_q - 1'b1;
                  end else begin
                     block_x_d = block_x_q + 1'b1;
                  end
               end else begin
                  if (block_x_q == '0) begin
                     dir_left_d = 1'b0;
                     if (block_end != COLS_N) block_x_d = block_x_q + 1'b1;
                  end else begin
                     block_x_d = block_x_q - 1'b1;
                  end
               end
            end else begin
               tick_d = tick_q - 24'd1;
            end
         end

         S_JUDGE: begin
            state_d      = S_WAIT;
            wait_first_d = 1'b1;
            if (ov_hi > ov_lo) begin
               next_d = 1'b1;
               if (level < LAST_LEVEL) begin
                  block_x_d = ov_lo[COL_W-1:0];
                  base_x_d  = ov_lo[COL_W-1:0];
                  block_w_d = ov_hi - ov_lo;
                  base_w_d  = ov_hi - ov_lo;
               end else begin
                  block_x_d  = '0;
                  block_w_d  = INIT_W;
                  base_x_d   = BASE_X0;
                  base_w_d   = INIT_W;
                  dir_left_d = 1'b0;
               end
            end else begin
               fail_d     = 1'b1;
               block_x_d  = '0;
               block_w_d  = INIT_W;
               base_x_d   = BASE_X0;
               base_w_d   = INIT_W;
               dir_left_d = 1'b0;
            end
         end

         S_WAIT: begin
            // The first wait cycle carries the result pulse; done_plot is only trusted after it.
            wait_first_d = 1'b0;
            if (!wait_first_q && done_plot) begin
               block_x_d  = '0;
               dir_left_d = 1'b0;
               tick_d     = period_m1(level);
               state_d    = S_MOVE;
            end
         end

         default: begin
            state_d = S_MOVE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= S_MOVE;
         block_x_q    <= '0;
         block_w_q    <= INIT_W;
         base_x_q     <= BASE_X0;
         base_w_q     <= INIT_W;
         dir_left_q   <= 1'b0;
         tick_q       <= period_m1(4'd0);
         wait_first_q <= 1'b0;
         next_q       <= 1'b0;
         fail_q       <= 1'b0;
         plot_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         block_x_q    <= block_x_d;
         block_w_q    <= block_w_d;
         base_x_q     <= base_x_d;
         base_w_q     <= base_w_d;
         dir_left_q   <= dir_left_d;
         tick_q       <= tick_d;
         wait_first_q <= wait_first_d;
         next_q       <= next_d;
         fail_q       <= fail_d;
         plot_q       <= plot_d;
      end
   end

   assign block_x     = block_x_q;
   assign block_w     = block_w_q;
   assign base_x      = base_x_q;
   assign base_w      = base_w_q;
   assign next_signal = next_q;
   assign fail        = fail_q;
   assign plot_req    = plot_q;

endmodule
